multiplier_4x4: RTL and testbench

4-bit x 4-bit unsigned multiplier producing an 8-bit product.
- Main result is purely combinational, built as an explicit array of AND-gate partial products and ripple full-adder rows.
- A registered copy with a valid flag is also provided for synchronous consumers.
- Used as a leaf arithmetic block in datapaths that need a small zero-latency multiply.

---
 rtl/multiplier_4x4.sv | 68 ++++++
 tb/tb_multiplier_4x4.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multiplier_4x4.sv
// 4x4 multiplier built from an AND-gate partial-product array and ripple adder rows, plus a registered copy.
// Optional MULTIPLIER_4X4_SIGNED_EN adds is_signed for two's complement operands (Baugh-Wooley).
module multiplier_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       in_valid,
`ifdef MULTIPLIER_4X4_SIGNED_EN
  input  logic       is_signed,
`endif
  output logic [7:0] product,
  output logic [7:0] product_q,
  output logic       out_valid
);

  logic            sgn;
  logic [3:0][3:0] pp;   // pp[i][j] = A[j] & B[i]
  logic [3:0][3:0] hi;   // hi[r]: running sum bits r+1 .. r+4 after row r
  logic [3:1][3:0] sum;
  logic [3:1][4:0] cy;

`ifdef MULTIPLIER_4X4_SIGNED_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b0;
`endif

  // Baugh-Wooley: invert the mixed sign-bit products, then add 2^4 (seeded into
  // the top of row 0) and 2^7 (folded in as an inversion of the MSB).
  always_comb begin
    pp      = '0;
    hi      = '0;
    sum     = '0;
    cy      = '0;
    product = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        pp[i][j] = (A[j] & B[i]) ^ (sgn & ((i == 3) != (j == 3)));
      end
    end
    product[0] = pp[0][0];
    hi[0]      = {sgn, pp[0][3:1]};
    for (int unsigned r = 1; r < 4; r++) begin
      cy[r][0] = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        sum[r][k]  = hi[r-1][k] ^ pp[r][k] ^ cy[r][k];
        cy[r][k+1] = (hi[r-1][k] & pp[r][k]) | (cy[r][k] & (hi[r-1][k] ^ pp[r][k]));
      end
      product[r] = sum[r][0];
      hi[r]      = {cy[r][4], sum[r][3:1]};
    end
    product[7:4] = {hi[3][3] ^ sgn, hi[3][2:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      product_q <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      product_q <= product;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplier_4x4.sv
// Self-checking bench for multiplier_4x4: literal vectors, exhaustive comb sweep, and a
// per-cycle comparison of both paths against an arithmetic reference model.
module tb_multiplier_4x4;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       in_valid = 1'b0;
  logic       is_signed = 1'b0;
  logic [7:0] product;
  logic [7:0] product_q;
  logic       out_valid;

  int checks = 0;
  int failures = 0;
  logic       run_chk = 1'b0;
  logic [7:0] exp_q = '0;
  logic       exp_v = 1'b0;

  multiplier_4x4 dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
`ifdef MULTIPLIER_4X4_SIGNED_EN
    .is_signed (is_signed),
`endif
    .product   (product),
    .product_q (product_q),
    .out_valid (out_valid)
  );

  always #5 if (clk_en) clk = ~clk;

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x, y;
    x = int'(a);
    y = int'(b);
    if (s && a[3]) x = x - 16;
    if (s && b[3]) y = y - 16;
    return 8'(x * y);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (A=%h B=%h t=%0t)", nm, act, exp, A, B, $time);
    end
  endtask

  // Reference for the registered path
  always @(posedge clk) begin
    if (rst) begin
      exp_q = 8'h00;
      exp_v = 1'b0;
    end else if (in_valid) begin
      exp_q = ref_mul(A, B, is_signed);
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("cyc_product", product, ref_mul(A, B, is_signed));
      chk("cyc_product_q", product_q, exp_q);
      chk("cyc_out_valid", {7'd0, out_valid}, {7'd0, exp_v});
    end
  end

  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b);
    in_valid = v;
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  ta [8] = '{4'd0, 4'd5, 4'd14, 4'd11, 4'd6, 4'd9, 4'd13, 4'd15};
  logic [3:0]  tb [8] = '{4'd0, 4'd3, 4'd0,  4'd1,  4'd15, 4'd2, 4'd10, 4'd15};
  logic [7:0]  te [8] = '{8'h00, 8'h0F, 8'h00, 8'h0B, 8'h5A, 8'h12, 8'h82, 8'hE1};

  initial begin
    // Comb path with the clock stopped
    for (int i = 0; i < 8; i++) begin
      A = ta[i];
      B = tb[i];
      #2;
      chk("comb_literal", product, te[i]);
    end
    rst = 1'b1;
    A = 4'd7;
    B = 4'd9;
    #2;
    chk("comb_rst_indep", product, 8'h3F);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = 4'(a);
        B = 4'(b);
        #2;
        chk("comb_exhaustive", product, 8'(a * b));
      end
    end
`ifdef MULTIPLIER_4X4_SIGNED_EN
    is_signed = 1'b1; A = 4'hF; B = 4'h3; #2; chk("signed_m1x3", product, 8'hFD);
    is_signed = 1'b0;                      #2; chk("unsigned_15x3", product, 8'h2D);
    is_signed = 1'b1; A = 4'h8; B = 4'h8; #2; chk("signed_m8xm8", product, 8'h40);
    A = 4'h7;                              #2; chk("signed_7xm8", product, 8'hC8);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = 4'(a);
        B = 4'(b);
        #2;
        chk("comb_signed_exh", product, ref_mul(A, B, 1'b1));
      end
    end
    is_signed = 1'b0;
`endif

    // Registered path: reset beats in_valid
    rst = 1'b1;
    clk_en = 1'b1;
    step(1'b1, 4'd15, 4'd15);
    run_chk = 1'b1;
    chk("rst_q_1", product_q, 8'h00);
    chk("rst_v_1", {7'd0, out_valid}, 8'h00);
    step(1'b1, 4'd15, 4'd15);
    chk("rst_q_2", product_q, 8'h00);
    chk("rst_v_2", {7'd0, out_valid}, 8'h00);
    rst = 1'b0;
    step(1'b1, 4'd15, 4'd15);
    chk("post_rst_q", product_q, 8'hE1);
    chk("post_rst_v", {7'd0, out_valid}, 8'h01);

    // Back-to-back handshake
    step(1'b1, 4'd2, 4'd3);
    chk("hs_q0", product_q, 8'h06);
    chk("hs_v0", {7'd0, out_valid}, 8'h01);
    step(1'b1, 4'd4, 4'd4);
    chk("hs_q1", product_q, 8'h10);
    chk("hs_v1", {7'd0, out_valid}, 8'h01);
    step(1'b1, 4'd7, 4'd9);
    chk("hs_q2", product_q, 8'h3F);
    chk("hs_v2", {7'd0, out_valid}, 8'h01);
    step(1'b0, 4'd1, 4'd1);
    chk("hs_hold_q", product_q, 8'h3F);
    chk("hs_hold_v", {7'd0, out_valid}, 8'h00);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 31) == 0);
`ifdef MULTIPLIER_4X4_SIGNED_EN
      is_signed = 1'($urandom_range(0, 1));
`endif
      step(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    rst = 1'b0;
    step(1'b0, 4'd0, 4'd0);
    @(negedge clk);
    run_chk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
